multicycle_ctrl_fsm: RTL and testbench

Control sequencer for the multi-cycle MIPS datapath variant.
- Reads the 6-bit opcode held in the instruction register and steps the shared ALU, memory, register file and PC through the states each instruction class needs.
- Drives every write enable and mux select of that datapath.
- Stretches fetch and memory states until the unified instruction/data memory reports ready.
- Sits between the IR opcode field and the datapath control inputs; replaces the single-cycle combinational control unit.

---
 rtl/multicycle_ctrl_fsm.sv | 237 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
// Control sequencer for the multi-cycle MIPS datapath. Reads the IR opcode
// field, walks the shared ALU / memory / register file / PC through the
// states each instruction class needs, and drives every write enable and
// mux select of that datapath. FETCH, MEMRD and MEMWR stretch until the
// unified memory reports MemReady.
//
// Optional feature: define MC_IMM_ALU_EN to build the immediate-ALU path
// (addi/andi/ori/slti through IEXEC/IWB). Without it those opcodes decode
// as illegal and encodings 10/11 are unreachable.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   Opcode       IR[31:26], captured when leaving DECODE
//   MemReady     memory completes the current access this cycle
//   PCWrite, PCWriteCond, Branch, PCSource         PC update controls
//   IorD, MemRead, MemWrite, IRWrite               memory / IR controls
//   MemtoReg, RegDst, RegWrite                     register file controls
//   ALUSrcA, ALUSrcB, ALUOp                        ALU controls
//   IllegalOp    one-cycle pulse in DECODE on an unrecognised opcode
//   InstrDone    one-cycle pulse in the final state of each instruction
//   State        current state (debug)
//
// Handshake: MemReady is a completion strobe; a memory state keeps its
// request asserted each cycle until the cycle MemReady is 1, and that cycle
// is the last one of the access.
module multicycle_ctrl_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Opcode,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic [1:0]         Branch,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               IllegalOp,
    output logic               InstrDone,
    output logic [STATE_W-1:0] State
);

    localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXEC   = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_RWB    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_BRANCH = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_JUMP   = STATE_W'(9);
`ifdef MC_IMM_ALU_EN
    localparam logic [STATE_W-1:0] S_IEXEC  = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_IWB    = STATE_W'(11);

    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [STATE_W-1:0] decode_target;
    logic [5:0]         op_q;

    // State register, plus the opcode captured on the edge leaving DECODE so
    // later states do not depend on IR contents staying stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= 6'b000000;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= Opcode;
            end
        end
    end

    // Opcode class to first execute state; FETCH means unrecognised.
    always_comb begin
        decode_target = S_FETCH;
        case (Opcode)
            OP_RTYPE:        decode_target = S_EXEC;
            OP_LW, OP_SW:    decode_target = S_MEMADR;
            OP_BEQ, OP_BNE:  decode_target = S_BRANCH;
            OP_J:            decode_target = S_JUMP;
`ifdef MC_IMM_ALU_EN
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: decode_target = S_IEXEC;
`endif
            default:         decode_target = S_FETCH;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: state_d = decode_target;
            S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = MemReady ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
`ifdef MC_IMM_ALU_EN
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode. While reset is high the state register may still hold
    // an in-flight state, so outputs are forced to the idle FETCH pattern
    // with every enable low (this is what aborts a store in MEMWR).
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        Branch      = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 3'b000;
        PCSource    = 2'b00;
        IllegalOp   = 1'b0;
        InstrDone   = 1'b0;
        State       = state_q;
        if (reset) begin
            ALUSrcB = 2'b01;
            State   = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                S_DECODE: begin
                    // Speculative branch target into ALUOut.
                    ALUSrcB   = 2'b11;
                    IllegalOp = (decode_target == S_FETCH);
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite  = 1'b1;
                    MemtoReg  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite  = 1'b1;
                    IorD      = 1'b1;
                    InstrDone = MemReady;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 3'b010;
                end
                S_RWB: begin
                    RegWrite  = 1'b1;
                    RegDst    = 1'b1;
                    InstrDone = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 3'b001;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    Branch      = (op_q == OP_BNE) ? 2'b10 : 2'b01;
                    InstrDone   = 1'b1;
                end
                S_JUMP: begin
                    PCWrite   = 1'b1;
                    PCSource  = 2'b10;
                    InstrDone = 1'b1;
                end
`ifdef MC_IMM_ALU_EN
                S_IEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    case (op_q)
                        OP_ANDI: ALUOp = 3'b011;
                        OP_ORI:  ALUOp = 3'b100;
                        OP_SLTI: ALUOp = 3'b101;
                        default: ALUOp = 3'b000;
                    endcase
                end
                S_IWB: begin
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
`endif
                default: begin
                    // Unreachable encodings: everything stays low.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm. Inputs change on the falling edge,
// outputs are sampled 1 ns later, well away from the rising edge. Expected
// state sequences are queued per instruction and popped one per cycle.
module tb_multicycle_ctrl_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, instr_done;
    logic [1:0] branch, alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;

    int n_checks = 0;
    int n_bad    = 0;
    int cnt;
    logic [3:0] exp_q[$];

    multicycle_ctrl_fsm #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Opcode(opcode), .MemReady(mem_ready),
        .PCWrite(pc_write), .PCWriteCond(pc_write_cond), .Branch(branch),
        .IorD(iord), .MemRead(mem_read), .MemWrite(mem_write), .IRWrite(ir_write),
        .MemtoReg(mem_to_reg), .RegDst(reg_dst), .RegWrite(reg_write),
        .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .ALUOp(alu_op),
        .PCSource(pc_source), .IllegalOp(illegal_op), .InstrDone(instr_done),
        .State(state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive MemReady for this cycle and let combinational outputs settle.
    task automatic drive(input logic rdy);
        mem_ready = rdy;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic expect_state(input string tag);
        logic [3:0] e;
        e = exp_q.pop_front();
        check(tag, {28'd0, state}, {28'd0, e});
    endtask

    initial begin
        reset = 1'b1;
        opcode = 6'b000000;
        mem_ready = 1'b1;

        // Reset held two cycles
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            drive(1'b1);
            check("rst_state", {28'd0, state}, 32'd0);
            check("rst_enables", {pc_write, pc_write_cond, ir_write, mem_read,
                  mem_write, reg_write, illegal_op, instr_done}, 32'd0);
            check("rst_alusrcb", {30'd0, alu_src_b}, 32'd1);
        end
        reset = 1'b0;
        drive(1'b1);
        check("rel_memread", {31'd0, mem_read}, 32'd1);
        check("rel_alusrcb", {30'd0, alu_src_b}, 32'd1);
        check("rel_pcwrite", {31'd0, pc_write}, 32'd1);

        // lw, MemReady=1; opcode scrambled after DECODE must be ignored
        opcode = 6'b100011;
        exp_q = {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        for (int c = 1; c <= 5; c++) begin
            if (c == 3) opcode = 6'b111111;
            drive(1'b1);
            expect_state("lw_state");
            check("lw_memtoreg", {31'd0, mem_to_reg}, 32'(c == 5));
            check("lw_regwrite", {31'd0, reg_write}, 32'(c == 5));
            check("lw_done", {31'd0, instr_done}, 32'(c == 5));
            next_cycle();
        end
        drive(1'b1);
        expect_state("lw_end");

        // sw with MemReady=0 for 3 cycles in MEMWR
        opcode = 6'b101011;
        exp_q = {4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
        cnt = 0;
        for (int c = 1; c <= 7; c++) begin
            drive(!(c >= 4 && c <= 6));
            expect_state("sw_state");
            if (mem_write) cnt++;
            check("sw_done", {31'd0, instr_done}, 32'(c == 7));
            next_cycle();
        end
        drive(1'b1);
        expect_state("sw_end");
        check("sw_memwrite_cycles", 32'(cnt), 32'd4);

        // bne
        opcode = 6'b000101;
        exp_q = {4'd0, 4'd1, 4'd8, 4'd0};
        drive(1'b1); expect_state("bne_state"); next_cycle();
        drive(1'b1); expect_state("bne_state");
        check("bne_dec_alusrcb", {30'd0, alu_src_b}, 32'd3);
        next_cycle();
        drive(1'b1); expect_state("bne_state");
        check("bne_branch", {30'd0, branch}, 32'd2);
        check("bne_aluop", {29'd0, alu_op}, 32'd1);
        check("bne_pcwritecond", {31'd0, pc_write_cond}, 32'd1);
        check("bne_pcsource", {30'd0, pc_source}, 32'd1);
        check("bne_done", {31'd0, instr_done}, 32'd1);
        next_cycle();
        drive(1'b1); expect_state("bne_end");

        // beq
        opcode = 6'b000100;
        exp_q = {4'd0, 4'd1, 4'd8, 4'd0};
        drive(1'b1); expect_state("beq_state"); next_cycle();
        drive(1'b1); expect_state("beq_state"); next_cycle();
        drive(1'b1); expect_state("beq_state");
        check("beq_branch", {30'd0, branch}, 32'd1);
        next_cycle();
        drive(1'b1); expect_state("beq_end");

        // R-type with one stalled FETCH cycle
        opcode = 6'b000000;
        exp_q = {4'd0, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        drive(1'b0); expect_state("r_state");
        check("r_stall_irwrite", {31'd0, ir_write}, 32'd0);
        check("r_stall_pcwrite", {31'd0, pc_write}, 32'd0);
        next_cycle();
        drive(1'b1); expect_state("r_state");
        check("r_irwrite", {31'd0, ir_write}, 32'd1);
        next_cycle();
        drive(1'b1); expect_state("r_state"); next_cycle();
        drive(1'b1); expect_state("r_state");
        check("r_exec_aluop", {29'd0, alu_op}, 32'd2);
        check("r_exec_alusrca", {31'd0, alu_src_a}, 32'd1);
        next_cycle();
        drive(1'b1); expect_state("r_state");
        check("r_rwb_regdst", {31'd0, reg_dst}, 32'd1);
        check("r_rwb_regwrite", {31'd0, reg_write}, 32'd1);
        check("r_rwb_done", {31'd0, instr_done}, 32'd1);
        next_cycle();
        drive(1'b1); expect_state("r_end");

        // j
        opcode = 6'b000010;
        exp_q = {4'd0, 4'd1, 4'd9, 4'd0};
        drive(1'b1); expect_state("j_state"); next_cycle();
        drive(1'b1); expect_state("j_state"); next_cycle();
        drive(1'b1); expect_state("j_state");
        check("j_pcwrite", {31'd0, pc_write}, 32'd1);
        check("j_pcsource", {30'd0, pc_source}, 32'd2);
        next_cycle();
        drive(1'b1); expect_state("j_end");

        // Illegal opcode 111111
        opcode = 6'b111111;
        exp_q = {4'd0, 4'd1, 4'd0};
        drive(1'b1); expect_state("ill_state");
        check("ill_fetch", {31'd0, illegal_op}, 32'd0);
        next_cycle();
        drive(1'b1); expect_state("ill_state");
        check("ill_pulse", {31'd0, illegal_op}, 32'd1);
        check("ill_no_done", {31'd0, instr_done}, 32'd0);
        next_cycle();
        drive(1'b1); expect_state("ill_end");
        check("ill_cleared", {31'd0, illegal_op}, 32'd0);

        // addi: legal only with the immediate-ALU build
        opcode = 6'b001000;
`ifdef MC_IMM_ALU_EN
        exp_q = {4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
        drive(1'b1); expect_state("addi_state"); next_cycle();
        drive(1'b1); expect_state("addi_state");
        check("addi_no_illegal", {31'd0, illegal_op}, 32'd0);
        next_cycle();
        drive(1'b1); expect_state("addi_state");
        check("addi_aluop", {29'd0, alu_op}, 32'd0);
        check("addi_alusrcb", {30'd0, alu_src_b}, 32'd2);
        next_cycle();
        drive(1'b1); expect_state("addi_state");
        check("addi_regwrite", {31'd0, reg_write}, 32'd1);
        next_cycle();
        drive(1'b1); expect_state("addi_end");
`else
        exp_q = {4'd0, 4'd1, 4'd0};
        drive(1'b1); expect_state("addi_state"); next_cycle();
        drive(1'b1); expect_state("addi_state");
        check("addi_illegal", {31'd0, illegal_op}, 32'd1);
        next_cycle();
        drive(1'b1); expect_state("addi_end");
`endif

        // Reset during MEMRD of a stalled lw
        opcode = 6'b100011;
        exp_q = {4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        cnt = 0;
        for (int c = 1; c <= 4; c++) begin
            drive(c < 4);
            expect_state("rstrd_state");
            if (reg_write) cnt++;
            next_cycle();
        end
        reset = 1'b1;
        drive(1'b0);
        if (reg_write) cnt++;
        check("rstrd_state_forced", {28'd0, state}, 32'd0);
        check("rstrd_memread", {31'd0, mem_read}, 32'd0);
        next_cycle();
        reset = 1'b0;
        drive(1'b1);
        if (reg_write) cnt++;
        expect_state("rstrd_fetch");
        check("rstrd_memread_after", {31'd0, mem_read}, 32'd1);
        check("rstrd_no_regwrite", 32'(cnt), 32'd0);

        // Reset during a stalled MEMWR aborts the store immediately
        opcode = 6'b101011;
        exp_q = {4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        for (int c = 1; c <= 4; c++) begin
            drive(c < 4);
            expect_state("rstwr_state");
            if (c == 4) check("rstwr_memwrite_before", {31'd0, mem_write}, 32'd1);
            next_cycle();
        end
        reset = 1'b1;
        drive(1'b0);
        check("rstwr_memwrite_abort", {31'd0, mem_write}, 32'd0);
        check("rstwr_no_done", {31'd0, instr_done}, 32'd0);
        next_cycle();
        reset = 1'b0;
        drive(1'b1);
        expect_state("rstwr_fetch");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
